mio_bus_ctrl: RTL and testbench
===============================

MIO_BUS_CTRL -- requirements
Module: mio_bus_ctrl

Interface
REQ-001 Parameter RAM_WAIT, 2, RAM read wait cycles (range 1..15).
REQ-002 Parameter RAM_AW, 10, RAM word-address width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-low (rst=0 resets on the next clk edge).
REQ-005 mem_req  in  1  CPU access request; held stable with addr_bus, mem_w and Cpu_data2bus until MIO_ready=1 is sampled.
REQ-006 mem_w  in  1  1=write, 0=read.
REQ-007 addr_bus  in  32  CPU byte address (M_addr).
REQ-008 Cpu_data2bus  in  32  write data (data_out).
REQ-009 sw  in  16  switch inputs.
REQ-010 ram_dout  in  32  synchronous RAM read data, valid one cycle after ram_addr.
REQ-011 data2CPU  out  32  registered read data to CPU.
REQ-012 MIO_ready  out  1  1=no stall; the CPU gates PC/IR updates with it.
REQ-013 ram_addr  out  RAM_AW  = addr_bus[RAM_AW+1:2], combinational.
REQ-014 ram_we  out  1  RAM write strobe.
REQ-015 ram_din  out  32  = Cpu_data2bus, combinational.
REQ-016 led  out  8  LED register.
REQ-017 counter_val  out  32  free-running counter value.

Function
REQ-018 Decode on addr_bus[31:28]: 0x0 RAM; 0xE switches (read-only, data={16'b0,sw}); 0xF with addr[2]=0 LED register, addr[2]=1 counter; all other values unmapped.
REQ-019 FSM states IDLE, WAIT, DONE; "accept" = clock edge where state=IDLE and mem_req=1.
REQ-020 MIO_ready = 1 when (IDLE and mem_req=0) or DONE; 0 otherwise (combinational).
REQ-021 RAM read: accept -> WAIT; remain in WAIT for exactly RAM_WAIT cycles; at the last WAIT edge capture ram_dout into data2CPU; -> DONE; MIO_ready=1 on cycle T0+RAM_WAIT+1 after the accept cycle T0.
REQ-022 RAM write: ram_we=1 combinationally only during the accept cycle (IDLE, mem_req=1, mem_w=1, RAM decode); accept -> DONE.
REQ-023 Peripheral/unmapped access: accept -> DONE; reads capture data2CPU at the accept edge; unmapped reads return 0; unmapped/switch writes are ignored.
REQ-024 LED write loads Cpu_data2bus[7:0] at the accept edge; LED read returns {24'b0,led}.
REQ-025 Counter increments by 1 every cycle, wrapping 0xFFFFFFFF->0; a counter write loads Cpu_data2bus at the accept edge (write wins over increment); a read returns the pre-edge value.
REQ-026 DONE lasts one cycle, then -> IDLE unconditionally; mem_req still high in the following IDLE cycle is a new access.
REQ-027 data2CPU holds its value outside capture edges; writes do not modify data2CPU.
REQ-028 mem_req changes during WAIT are ignored; the access completes with the values latched at accept.
REQ-029 Address/write-enable for WAIT comes from an internal register latched at accept, not from addr_bus.

Reset
REQ-030 On rst=0 at a clk edge: state=IDLE, data2CPU=0, led=0, counter_val=0, latched request cleared.
REQ-031 Reset during WAIT aborts the access, producing no data capture and no DONE cycle.
REQ-032 ram_we=0 while rst=0, so no write is issued in a reset cycle.

Structure
REQ-033 Shared package holds the FSM state encoding and the region decode constants (0x0, 0xE, 0xF).
REQ-034 One sub-module, mio_addr_dec: combinational addr_bus -> one-hot region select.
REQ-035 No latches; all outputs except MIO_ready, ram_addr, ram_din and ram_we are registered.

Verification
REQ-036 RAM read 0x0000_0010, RAM_WAIT=2, ram_dout=0xDEADBEEF -> MIO_ready low for 3 cycles, then data2CPU=0xDEADBEEF and MIO_ready=1 for one DONE cycle; ram_addr=4.
REQ-037 Write 0x5A to 0xF000_0000 -> led=0x5A after 1 edge; a read of the same address returns 0x0000005A.
REQ-038 Write 0x0000_0100 to 0xF000_0004 then idle 5 cycles -> counter_val=0x105; counter preset to 0xFFFFFFFF -> 0 on the next edge.
REQ-039 Read 0x8000_0000 -> data2CPU=0, one stall cycle; write there -> led and RAM unchanged, ram_we never 1.
REQ-040 rst=0 asserted during the 2nd WAIT cycle of a RAM read -> next cycle IDLE, data2CPU=0, MIO_ready=1 with mem_req=0.
REQ-041 Back-to-back: mem_req held through DONE -> second access accepted in the following IDLE cycle; switch read with sw=0x1234 returns 0x00001234.

Source files
------------

// File: rtl/mio_bus_ctrl_pkg.sv
// Shared types and constants for the memory-mapped I/O bus controller:
// FSM state encoding, region decode nibbles and the peripheral read mux.
package mio_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mio_state_e;

    // Values of addr_bus[31:28] that select each region
    localparam logic [3:0] REGION_RAM = 4'h0;
    localparam logic [3:0] REGION_SW  = 4'hE;
    localparam logic [3:0] REGION_IO  = 4'hF;

    // One-hot region select; exactly one field is set for any address
    typedef struct packed {
        logic ram;
        logic sw;
        logic led;
        logic cnt;
        logic unmapped;
    } region_sel_t;

    // Read data for the single-cycle regions; unmapped reads return zero
    function automatic logic [31:0] periph_rdata(
        input region_sel_t sel,
        input logic [15:0] sw,
        input logic [7:0]  led,
        input logic [31:0] cnt
    );
        logic [31:0] d;
        d = 32'h0000_0000;
        if (sel.sw) begin
            d = {16'h0000, sw};
        end else if (sel.led) begin
            d = {24'h00_0000, led};
        end else if (sel.cnt) begin
            d = cnt;
        end else begin
            d = 32'h0000_0000;
        end
        return d;
    endfunction

endpackage

// File: rtl/mio_addr_dec.sv
// Combinational address decoder: CPU byte address -> one-hot region select.
module mio_addr_dec
    import mio_bus_ctrl_pkg::*;
(
    input  logic [31:0] addr_bus,
    output region_sel_t sel
);

    // Only the top nibble and bit 2 take part in the decode
    logic unused_addr_s;
    assign unused_addr_s = ^{addr_bus[27:3], addr_bus[1:0]};

    // Region decode on the top nibble; the I/O page splits on bit 2
    always_comb begin
        sel = '0;
        case (addr_bus[31:28])
            REGION_RAM: sel.ram = 1'b1;
            REGION_SW:  sel.sw  = 1'b1;
            REGION_IO: begin
                if (addr_bus[2]) begin
                    sel.cnt = 1'b1;
                end else begin
                    sel.led = 1'b1;
                end
            end
            default:    sel.unmapped = 1'b1;
        endcase
    end

endmodule

// File: rtl/mio_bus_ctrl.sv
// Memory-mapped I/O bus controller: stalls the CPU for RAM reads, serves
// switches / LED register / free-running counter in a single access cycle.
module mio_bus_ctrl
    import mio_bus_ctrl_pkg::*;
#(
    parameter int RAM_WAIT = 2,
    parameter int RAM_AW   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              mem_w,
    input  logic [31:0]       addr_bus,
    input  logic [31:0]       Cpu_data2bus,
    input  logic [15:0]       sw,
    input  logic [31:0]       ram_dout,
    output logic [31:0]       data2CPU,
    output logic              MIO_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_din,
    output logic [7:0]        led,
    output logic [31:0]       counter_val
);

    // Countdown start so that WAIT lasts exactly RAM_WAIT cycles
    localparam logic [3:0] WAIT_LOAD_C = 4'(RAM_WAIT - 1);

    mio_state_e  state_r;
    mio_state_e  state_nxt_s;
    region_sel_t sel_s;
    region_sel_t lat_sel_r;
    logic        lat_we_r;
    logic [3:0]  wait_cnt_r;
    logic [31:0] data_r;
    logic [7:0]  led_r;
    logic [31:0] counter_r;
    logic        accept_s;
    logic        last_wait_s;
    logic        ready_s;
    logic        we_s;

    mio_addr_dec u_addr_dec (
        .addr_bus (addr_bus),
        .sel      (sel_s)
    );

    // RAM word address and write data pass straight through from the CPU
    assign ram_addr    = addr_bus[RAM_AW+1:2];
    assign ram_din     = Cpu_data2bus;
    assign ram_we      = we_s;
    assign MIO_ready   = ready_s;
    assign data2CPU    = data_r;
    assign led         = led_r;
    assign counter_val = counter_r;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: only RAM reads pass through WAIT
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mem_req) begin
                    if (sel_s.ram && !mem_w) begin
                        state_nxt_s = ST_WAIT;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (last_wait_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: accept strobe, stall release, RAM write strobe
    always_comb begin
        accept_s    = 1'b0;
        last_wait_s = 1'b0;
        ready_s     = 1'b0;
        we_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                accept_s = mem_req;
                ready_s  = ~mem_req;
                we_s     = mem_req & mem_w & sel_s.ram & rst;
            end
            ST_WAIT: last_wait_s = (wait_cnt_r == 4'd0);
            ST_DONE: ready_s = 1'b1;
            default: ready_s = 1'b0;
        endcase
    end

    // Request latch and wait countdown; WAIT never looks at addr_bus again
    always_ff @(posedge clk) begin
        if (!rst) begin
            lat_sel_r  <= '0;
            lat_we_r   <= 1'b0;
            wait_cnt_r <= 4'd0;
        end else if (accept_s) begin
            lat_sel_r  <= sel_s;
            lat_we_r   <= mem_w;
            wait_cnt_r <= WAIT_LOAD_C;
        end else if ((state_r == ST_WAIT) && (wait_cnt_r != 4'd0)) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
        end
    end

    // Read data: peripherals captured at accept, RAM at the last WAIT edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_r <= 32'h0000_0000;
        end else if (accept_s && !mem_w && !sel_s.ram) begin
            data_r <= periph_rdata(sel_s, sw, led_r, counter_r);
        end else if (last_wait_s && lat_sel_r.ram && !lat_we_r) begin
            data_r <= ram_dout;
        end
    end

    // LED register, written at the accept edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            led_r <= 8'h00;
        end else if (accept_s && mem_w && sel_s.led) begin
            led_r <= Cpu_data2bus[7:0];
        end
    end

    // Free-running counter; a CPU write takes priority over the increment
    always_ff @(posedge clk) begin
        if (!rst) begin
            counter_r <= 32'h0000_0000;
        end else if (accept_s && mem_w && sel_s.cnt) begin
            counter_r <= Cpu_data2bus;
        end else begin
            counter_r <= counter_r + 32'd1;
        end
    end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Self-checking bench for mio_bus_ctrl: directed scenarios followed by
// randomized accesses checked against a transaction-level model.
module tb_mio_bus_ctrl;

    localparam int RAM_WAIT_P = 2;
    localparam int RAM_AW_P   = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_w = 1'b0;
    logic [31:0] addr_bus = 32'h0;
    logic [31:0] Cpu_data2bus = 32'h0;
    logic [15:0] sw = 16'h0;
    logic [31:0] ram_dout;
    logic [31:0] data2CPU;
    logic        MIO_ready;
    logic [9:0]  ram_addr;
    logic        ram_we;
    logic [31:0] ram_din;
    logic [7:0]  led;
    logic [31:0] counter_val;

    always #5 clk = ~clk;

    mio_bus_ctrl #(.RAM_WAIT(RAM_WAIT_P), .RAM_AW(RAM_AW_P)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_w(mem_w),
        .addr_bus(addr_bus), .Cpu_data2bus(Cpu_data2bus), .sw(sw),
        .ram_dout(ram_dout), .data2CPU(data2CPU), .MIO_ready(MIO_ready),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
        .led(led), .counter_val(counter_val)
    );

    // Synchronous RAM: data appears one cycle after the address
    logic [31:0] mem [0:1023];
    logic        init_we = 1'b0;
    logic [9:0]  init_idx = 10'h0;
    logic [31:0] init_val = 32'h0;
    always @(posedge clk) begin
        if (init_we) mem[init_idx] <= init_val;
        else if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    // Edge counter and RAM write-strobe counter
    int unsigned cyc = 0;
    int unsigned we_cnt = 0;
    always @(posedge clk) begin
        cyc++;
        if (ram_we === 1'b1) we_cnt++;
    end

    // Reference model state
    logic [31:0] ref_ram [0:1023];
    logic [7:0]  exp_led = 8'h0;
    logic [31:0] exp_data = 32'h0;
    logic [31:0] ld_val = 32'h0;
    int unsigned ld_cyc = 0;
    int unsigned exp_we = 0;
    int          ncomp = 0;
    int          nfail = 0;

    // Current access
    logic        cur_w;
    logic [31:0] cur_a, cur_d, pre_cnt;
    int unsigned start_cyc;
    int          cur_lead;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        ncomp++;
        assert (obs === want) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    function automatic int region_of(input logic [31:0] a);
        int top;
        top = int'(a >> 28);
        if (top == 0) return 0;
        if (top == 14) return 1;
        if (top == 15) return (a[2] ? 3 : 2);
        return 4;
    endfunction

    function automatic logic [31:0] exp_cnt();
        return ld_val + 32'(cyc - ld_cyc);
    endfunction

    // lead = edges before the accept edge (1 when chained after a DONE cycle)
    task automatic start_access(input logic w, input logic [31:0] a, input logic [31:0] d, input int lead);
        mem_req = 1'b1; mem_w = w; addr_bus = a; Cpu_data2bus = d;
        cur_w = w; cur_a = a; cur_d = d; cur_lead = lead;
        start_cyc = cyc;
        pre_cnt = ld_val + 32'(cyc + unsigned'(lead) - ld_cyc);
    endtask

    task automatic finish_access(input bit drop);
        int stall;
        int rg;
        int exp_stall;
        stall = 0;
        @(negedge clk);
        while (MIO_ready !== 1'b1 && stall < 64) begin
            stall++;
            @(negedge clk);
        end
        rg = region_of(cur_a);
        exp_stall = (rg == 0 && !cur_w) ? RAM_WAIT_P + 1 : 1;
        if (cur_w) begin
            case (rg)
                0: begin ref_ram[cur_a[11:2]] = cur_d; exp_we++; end
                2: exp_led = cur_d[7:0];
                3: begin ld_val = cur_d; ld_cyc = start_cyc + unsigned'(cur_lead) + 1; end
                default: ;
            endcase
        end else begin
            case (rg)
                0: exp_data = ref_ram[cur_a[11:2]];
                1: exp_data = {16'h0, sw};
                2: exp_data = {24'h0, exp_led};
                3: exp_data = pre_cnt;
                default: exp_data = 32'h0;
            endcase
        end
        check("stall", 32'(stall), 32'(exp_stall));
        check("data2CPU", data2CPU, exp_data);
        check("led", {24'h0, led}, {24'h0, exp_led});
        check("counter", counter_val, exp_cnt());
        check("ram_we_count", 32'(we_cnt), 32'(exp_we));
        if (drop) begin
            mem_req = 1'b0;
            mem_w = 1'b0;
        end
    endtask

    initial begin
        int          kind;
        logic        rw;
        logic [31:0] a, d, r;
        logic [3:0]  nib;
        bit          chained;
        bit          keep;

        // Reset held while the RAM is preloaded
        rst = 1'b0;
        init_we = 1'b1;
        for (int i = 0; i < 16; i++) begin
            init_idx = 10'(i);
            init_val = (i == 4) ? 32'hDEAD_BEEF : $urandom;
            ref_ram[i] = init_val;
            @(posedge clk); #1;
        end
        init_we = 1'b0;
        @(negedge clk);
        check("rst_data2CPU", data2CPU, 32'h0);
        check("rst_led", {24'h0, led}, 32'h0);
        check("rst_counter", counter_val, 32'h0);
        check("rst_ready", {31'h0, MIO_ready}, 32'h1);
        mem_req = 1'b1; mem_w = 1'b1; addr_bus = 32'h0000_0008;
        #1;
        check("rst_no_we", {31'h0, ram_we}, 32'h0);
        mem_req = 1'b0; mem_w = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        ld_val = 32'h0; ld_cyc = cyc;

        // RAM read with wait states
        @(posedge clk); #1;
        start_access(1'b0, 32'h0000_0010, 32'h0, 0);
        #2;
        check("ram_addr", {22'h0, ram_addr}, 32'd4);
        finish_access(1'b1);
        check("ram_read_deadbeef", data2CPU, 32'hDEAD_BEEF);

        // LED write then read back
        @(posedge clk); #1; start_access(1'b1, 32'hF000_0000, 32'h0000_005A, 0); finish_access(1'b1);
        check("led_5a", {24'h0, led}, 32'h5A);
        @(posedge clk); #1; start_access(1'b0, 32'hF000_0000, 32'h0, 0); finish_access(1'b1);
        check("led_read", data2CPU, 32'h0000_005A);

        // Counter preset, run, and wrap
        @(posedge clk); #1; start_access(1'b1, 32'hF000_0004, 32'h0000_0100, 0); finish_access(1'b1);
        repeat (5) @(negedge clk);
        check("counter_105", counter_val, 32'h0000_0105);
        @(posedge clk); #1; start_access(1'b1, 32'hF000_0004, 32'hFFFF_FFFF, 0); finish_access(1'b1);
        @(negedge clk);
        check("counter_wrap", counter_val, 32'h0);
        @(posedge clk); #1; start_access(1'b0, 32'hF000_0004, 32'h0, 0); finish_access(1'b1);

        // Unmapped read and write; switch write ignored
        @(posedge clk); #1; start_access(1'b0, 32'h8000_0000, 32'h0, 0); finish_access(1'b1);
        check("unmapped_read", data2CPU, 32'h0);
        @(posedge clk); #1; start_access(1'b1, 32'h8000_0000, 32'h0000_00FF, 0); finish_access(1'b1);
        @(posedge clk); #1; start_access(1'b1, 32'hE000_0000, 32'h0000_00FF, 0); finish_access(1'b1);

        // RAM write then read back
        @(posedge clk); #1; start_access(1'b1, 32'h0000_0014, 32'h1357_9BDF, 0); finish_access(1'b1);
        @(posedge clk); #1; start_access(1'b0, 32'h0000_0014, 32'h0, 0); finish_access(1'b1);
        check("ram_wr_rd", data2CPU, 32'h1357_9BDF);

        // Back-to-back: LED read held through DONE, then switch read
        sw = 16'h1234;
        @(posedge clk); #1; start_access(1'b0, 32'hF000_0000, 32'h0, 0); finish_access(1'b0);
        start_access(1'b0, 32'hE000_0000, 32'h0, 1); finish_access(1'b1);
        check("switch_1234", data2CPU, 32'h0000_1234);

        // Reset during the second WAIT cycle of a RAM read
        @(posedge clk); #1; start_access(1'b0, 32'h0000_0020, 32'h0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; mem_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        ld_val = 32'h0; ld_cyc = cyc; exp_led = 8'h0; exp_data = 32'h0;
        @(negedge clk);
        check("abort_ready", {31'h0, MIO_ready}, 32'h1);
        check("abort_data", data2CPU, 32'h0);
        check("abort_led", {24'h0, led}, 32'h0);
        check("abort_counter", counter_val, exp_cnt());
        repeat (3) @(negedge clk);
        check("abort_no_done", data2CPU, 32'h0);

        // Randomized accesses against the model
        chained = 1'b0;
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 4);
            rw = 1'($urandom_range(0, 1));
            r = $urandom;
            d = $urandom;
            case (kind)
                0: a = r & 32'h0FFF_F03C;
                1: a = 32'hE000_0000 | (r & 32'h0FFF_FFFF);
                2: a = 32'hF000_0000 | (r & 32'h0FFF_FFFB);
                3: a = 32'hF000_0004 | (r & 32'h0FFF_FFFF);
                default: begin
                    nib = 4'($urandom_range(1, 13));
                    a = {nib, r[27:0]};
                end
            endcase
            sw = 16'($urandom);
            keep = ($urandom_range(0, 3) == 0);
            if (!chained) begin
                @(posedge clk); #1;
            end
            start_access(rw, a, d, chained ? 1 : 0);
            finish_access(!keep);
            chained = keep;
            if (!keep && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
                check("idle_counter", counter_val, exp_cnt());
                check("idle_hold", data2CPU, exp_data);
            end
        end
        if (chained) begin
            mem_req = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("final_counter", counter_val, exp_cnt());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
